wb_sram_ctrl_512x32: RTL

//  Wishbone-slave initiator that drives two 256x32 1rw1r OpenRAM macros (banks 0/1) as one 512x32 RAM via port 0.

---
 rtl/wb_sram_ctrl_512x32.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wb_sram_ctrl_512x32.sv
// Wishbone classic slave that presents two 256x32 OpenRAM macros (port 0) as one 512x32 RAM.
// One SRAM strobe per WB cycle, registered ack; port 1 of both macros is kept deselected.
module wb_sram_ctrl_512x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int BANK_AW    = 8,
    parameter int NUM_BANKS  = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [NUM_WMASKS-1:0] wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic [NUM_BANKS-1:0]  sram_csb0_o,
    output logic                  sram_web0_o,
    output logic [NUM_WMASKS-1:0] sram_wmask0_o,
    output logic [BANK_AW-1:0]    sram_addr0_o,
    output logic [DATA_WIDTH-1:0] sram_din0_o,
    input  logic [DATA_WIDTH-1:0] sram_dout0_b0_i,
    input  logic [DATA_WIDTH-1:0] sram_dout0_b1_i,
    output logic [NUM_BANKS-1:0]  sram_csb1_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    logic [1:0]            r_state;
    logic                  r_we;
    logic                  r_bank;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [NUM_BANKS-1:0]  r_csb;
    logic                  r_web;
    logic [NUM_WMASKS-1:0] r_wmask;
    logic [BANK_AW-1:0]    r_addr;
    logic [DATA_WIDTH-1:0] r_din;

    logic                  w_req;
    logic                  w_bank;
    logic                  w_access;
    logic [NUM_BANKS-1:0]  w_csb_sel;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused_adr;

    assign w_req     = wbs_cyc_i & wbs_stb_i;
    assign w_bank    = wbs_adr_i[BANK_AW+2];
    assign w_csb_sel = w_bank ? 2'b01 : 2'b10;
    // A write with no byte lanes enabled is acked but never touches the macro.
    assign w_access  = (~wbs_we_i) | (|wbs_sel_i);
    assign w_rd_word = r_bank ? sram_dout0_b1_i : sram_dout0_b0_i;

    // Upper address bits are decoded upstream; byte offset is irrelevant for word access.
    assign w_unused_adr = &{1'b0, wbs_adr_i[31:BANK_AW+3], wbs_adr_i[1:0]};

    // Transaction FSM and all registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_bank  <= 1'b0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_csb   <= 2'b11;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 1'b0;
                    if (w_req) begin
                        r_we    <= wbs_we_i;
                        r_bank  <= w_bank;
                        r_addr  <= wbs_adr_i[BANK_AW+1:2];
                        r_din   <= wbs_dat_i;
                        r_web   <= ~wbs_we_i;
                        r_wmask <= wbs_we_i ? wbs_sel_i : {NUM_WMASKS{1'b0}};
                        r_csb   <= w_access ? w_csb_sel : 2'b11;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_csb <= 2'b11;
                    if (r_we) begin
                        r_ack   <= wbs_cyc_i;
                        r_state <= wbs_cyc_i ? ST_ACK : ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                // Read data is captured even if the master has abandoned the cycle.
                ST_WAIT: begin
                    r_dat   <= w_rd_word;
                    r_ack   <= wbs_cyc_i;
                    r_state <= wbs_cyc_i ? ST_ACK : ST_IDLE;
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_csb   <= 2'b11;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o     = r_ack;
    assign wbs_dat_o     = r_dat;
    assign sram_csb0_o   = r_csb;
    assign sram_web0_o   = r_web;
    assign sram_wmask0_o = r_wmask;
    assign sram_addr0_o  = r_addr;
    assign sram_din0_o   = r_din;
    assign sram_csb1_o   = 2'b11;

endmodule
